synth_bus_master: RTL and testbench

Bus initiator for the synth register bus: accepts register-write commands from the control side (sequencer, MIDI decoder, host bridge), buffers them in a small FIFO, and serialises each into one to three byte writes on the shared BusAddress/BusData/BusReadWrite/BusClock bus. It is the driving end of the bus that channel blocks decode. It owns BusClock and is the only initiator on the bus.

---
 rtl/synth_bus_pkg.sv | 35 +++
 rtl/synth_cmd_fifo.sv | 54 +++++
 rtl/synth_bus_master.sv | 143 ++++++++++++++
 tb/tb_synth_bus_master.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_bus_pkg.sv
// Shared definitions for the synth register bus: FSM states, field widths,
// command layout and the channel register map seen by responders.
package synth_bus_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int VALUE_W = 24;
    localparam int BYTES_W = 2;
    localparam int CMD_W   = ADDR_W + VALUE_W + BYTES_W;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } bus_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [VALUE_W-1:0] data;
        logic [BYTES_W-1:0] bytes;
    } bus_cmd_t;

    // Channel register offsets relative to a channel base address
    localparam logic [7:0] GATE       = 8'd0;
    localparam logic [7:0] INCR       = 8'd1;
    localparam logic [7:0] WAVETYPE   = 8'd4;
    localparam logic [7:0] PULSEWIDTH = 8'd5;
    localparam logic [7:0] ATTACK     = 8'd8;
    localparam logic [7:0] DECAY      = 8'd11;
    localparam logic [7:0] SUSTAIN    = 8'd14;
    localparam logic [7:0] RELEASE    = 8'd17;
    localparam logic [7:0] LINEAR     = 8'd20;

endpackage

// File: rtl/synth_cmd_fifo.sv
// Show-ahead command FIFO: the head entry is visible on rdData whenever
// empty is low, and pop simply advances to the next entry.
module synth_cmd_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/synth_bus_master.sv
// Synth register bus initiator: queues register-write commands and
// serialises each into byte writes framed as SETUP / STROBE / HOLD phases.
module synth_bus_master
    import synth_bus_pkg::*;
#(
    parameter int DIV        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               CmdValid,
    output logic               CmdReady,
    input  logic [ADDR_W-1:0]  CmdAddr,
    input  logic [VALUE_W-1:0] CmdData,
    input  logic [BYTES_W-1:0] CmdBytes,
    output logic               Busy,
    output logic [ADDR_W-1:0]  BusAddress,
    inout  wire logic [DATA_W-1:0] BusData,
    output logic               BusReadWrite,
    output logic               BusClock
);

    localparam logic [7:0] PHASE_LOAD = 8'(DIV - 1);

    bus_cmd_t                     incoming;
    bus_cmd_t                     head;
    logic [CMD_W-1:0]             headBits;
    logic                         fifoPush;
    logic                         fifoPop;
    logic                         fifoFull;
    logic                         fifoEmpty;
    logic [$clog2(FIFO_DEPTH):0]  fifoCount;

    bus_state_e         state;
    bus_state_e         nextState;
    logic [7:0]         phase;
    logic [1:0]         byteIdx;
    logic [1:0]         byteCount;
    logic [ADDR_W-1:0]  addrReg;
    logic [VALUE_W-1:0] dataReg;
    logic               phaseDone;
    logic               lastByte;
    logic               loadCmd;
    logic               nextByte;

    assign incoming = '{addr: CmdAddr, data: CmdData, bytes: CmdBytes};
    assign head     = bus_cmd_t'(headBits);
    assign CmdReady = !fifoFull;
    assign fifoPush = CmdValid && CmdReady;

    synth_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) cmdFifo (
        .Clock  (Clock),
        .Reset  (Reset),
        .push   (fifoPush),
        .wrData (incoming),
        .pop    (fifoPop),
        .rdData (headBits),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    assign phaseDone = (phase == 8'd0);
    assign lastByte  = (byteIdx == byteCount - 2'd1);

    // A null command is popped and dropped without leaving IDLE
    always_comb begin
        nextState = state;
        fifoPop   = 1'b0;
        loadCmd   = 1'b0;
        nextByte  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    if (head.bytes != 2'd0) begin
                        loadCmd   = 1'b1;
                        nextState = SETUP;
                    end
                end
            end
            SETUP: begin
                if (phaseDone) nextState = STROBE;
            end
            STROBE: begin
                if (phaseDone) nextState = HOLD;
            end
            HOLD: begin
                if (phaseDone) begin
                    if (lastByte) begin
                        nextState = IDLE;
                    end else begin
                        nextByte  = 1'b1;
                        nextState = SETUP;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    // Data register shifts right so the current byte is always in bits 7:0
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            phase     <= 8'd0;
            byteIdx   <= 2'd0;
            byteCount <= 2'd0;
            addrReg   <= '0;
            dataReg   <= '0;
        end else begin
            if (nextState != state) begin
                phase <= PHASE_LOAD;
            end else if (!phaseDone) begin
                phase <= phase - 8'd1;
            end
            if (loadCmd) begin
                addrReg   <= head.addr;
                dataReg   <= head.data;
                byteCount <= head.bytes;
                byteIdx   <= 2'd0;
            end else if (nextByte) begin
                addrReg <= addrReg + 16'd1;
                dataReg <= {8'h00, dataReg[VALUE_W-1:DATA_W]};
                byteIdx <= byteIdx + 2'd1;
            end
        end
    end

    assign BusReadWrite = (state != IDLE);
    assign BusClock     = (state == STROBE);
    assign BusAddress   = addrReg;
    assign BusData      = BusReadWrite ? dataReg[DATA_W-1:0] : 8'hzz;
    assign Busy         = (fifoCount != '0) || (state != IDLE);

endmodule

// File: tb/tb_synth_bus_master.sv
// Directed bench for synth_bus_master: logs every bus write seen at a
// BusClock rising edge and compares against hand-computed expectations.
module tb_synth_bus_master;

    localparam int DIV        = 2;
    localparam int FIFO_DEPTH = 4;

    logic        Clock    = 1'b0;
    logic        Reset    = 1'b0;
    logic        CmdValid = 1'b0;
    logic [15:0] CmdAddr  = 16'h0000;
    logic [23:0] CmdData  = 24'h000000;
    logic [1:0]  CmdBytes = 2'd0;
    wire         CmdReady;
    wire         Busy;
    wire  [15:0] BusAddress;
    wire  [7:0]  BusData;
    wire         BusReadWrite;
    wire         BusClock;

    int          testsRun    = 0;
    int          testsFailed = 0;
    time         acceptTime  = 0;
    logic [23:0] busLog [$];
    time         riseLog [$];

    synth_bus_master #(
        .DIV        (DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .CmdValid     (CmdValid),
        .CmdReady     (CmdReady),
        .CmdAddr      (CmdAddr),
        .CmdData      (CmdData),
        .CmdBytes     (CmdBytes),
        .Busy         (Busy),
        .BusAddress   (BusAddress),
        .BusData      (BusData),
        .BusReadWrite (BusReadWrite),
        .BusClock     (BusClock)
    );

    always #5 Clock = ~Clock;

    // Responder model: capture address and data on each strobe rising edge
    always @(posedge BusClock) begin
        if (Reset) begin
            busLog.push_back({BusAddress, BusData});
            riseLog.push_back($time);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Offer a command for up to budget cycles; stops driving once accepted
    task automatic applyStimulus(input logic [15:0] addr, input logic [23:0] data,
                                 input logic [1:0] bytes, input int budget,
                                 output bit accepted, output int lowCycles);
        accepted  = 1'b0;
        lowCycles = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge Clock);
            CmdValid = 1'b1;
            CmdAddr  = addr;
            CmdData  = data;
            CmdBytes = bytes;
            if (CmdReady) begin
                @(posedge Clock);
                acceptTime = $time;
                accepted   = 1'b1;
                #1 CmdValid = 1'b0;
                break;
            end
            lowCycles++;
        end
        if (!accepted) CmdValid = 1'b0;
    endtask

    // Latencies in Clock edges from refTime to bus-idle and to Busy falling
    task automatic waitDone(input time refTime, input int budget,
                            output int rwLat, output int busyLat);
        bit sawActive;
        int edgeCyc;
        sawActive = 1'b0;
        rwLat     = -1;
        busyLat   = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge Clock);
            edgeCyc = int'(($time - 5 - refTime) / 10);
            if (BusReadWrite) sawActive = 1'b1;
            else if (sawActive && rwLat < 0) rwLat = edgeCyc;
            if (!Busy) begin
                busyLat = edgeCyc;
                break;
            end
        end
        if (busyLat < 0) checkOutput("doneTimeout", 32'(Busy), 32'd0);
    endtask

    initial begin
        bit  acc;
        int  low;
        int  rwLat;
        int  busyLat;
        int  accCount;
        int  logAtReset;
        time refTime;
        bit  found;

        // Power-up reset, then a reset pulse while idle
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput("rstReady", 32'(CmdReady), 32'd1);
        checkOutput("rstBusy", 32'(Busy), 32'd0);
        checkOutput("rstAddr", 32'(BusAddress), 32'h0000);
        checkOutput("rstRw", 32'(BusReadWrite), 32'd0);
        checkOutput("rstClk", 32'(BusClock), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        // Three-byte write
        applyStimulus(16'h0101, 24'h123456, 2'd3, 10, acc, low);
        checkOutput("acc3", 32'(acc), 32'd1);
        refTime = acceptTime;
        #1 checkOutput("busyRise", 32'(Busy), 32'd1);
        waitDone(refTime, 60, rwLat, busyLat);
        checkOutput("busyFall3", 32'(busyLat), 32'd19);
        checkOutput("rwFall3", 32'(rwLat), 32'd19);
        checkOutput("log3Size", 32'(busLog.size()), 32'd3);
        checkOutput("log3b0", 32'(busLog[0]), 32'h010156);
        checkOutput("log3b1", 32'(busLog[1]), 32'h010234);
        checkOutput("log3b2", 32'(busLog[2]), 32'h010312);
        checkOutput("rise0", 32'((riseLog[0] - refTime) / 10), 32'd3);
        checkOutput("period01", 32'((riseLog[1] - riseLog[0]) / 10), 32'd6);
        checkOutput("period12", 32'((riseLog[2] - riseLog[1]) / 10), 32'd6);
        busLog.delete();
        riseLog.delete();

        // Single-byte write, upper data bytes ignored
        applyStimulus(16'h0000, 24'hABCD01, 2'd1, 10, acc, low);
        refTime = acceptTime;
        waitDone(refTime, 40, rwLat, busyLat);
        checkOutput("busyFall1", 32'(busyLat), 32'd7);
        repeat (10) @(negedge Clock);
        checkOutput("log1Size", 32'(busLog.size()), 32'd1);
        checkOutput("log1b0", 32'(busLog[0]), 32'h000001);
        checkOutput("idleRw", 32'(BusReadWrite), 32'd0);
        checkOutput("idleAddr", 32'(BusAddress), 32'h0000);
        busLog.delete();
        riseLog.delete();

        // Six commands offered back-to-back against a depth-4 FIFO
        accCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h0200 + 16'(i), 24'h0000A0 + 24'(i), 2'd1, 10, acc, low);
            if (acc) accCount++;
        end
        applyStimulus(16'h0205, 24'h0000A5, 2'd1, 4, acc, low);
        if (acc) accCount++;
        checkOutput("fullAccepted", 32'(accCount), 32'd5);
        checkOutput("readyLowCycles", 32'(low), 32'd4);
        @(negedge Clock);
        checkOutput("readyAfterDone", 32'(CmdReady), 32'd1);
        waitDone(acceptTime, 100, rwLat, busyLat);
        checkOutput("fullLogSize", 32'(busLog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("fullOrder%0d", i), 32'(busLog[i]),
                        32'({16'h0200 + 16'(i), 8'hA0 + 8'(i)}));
        end
        busLog.delete();
        riseLog.delete();

        // Address wrap followed by a null command
        applyStimulus(16'hFFFF, 24'h00BEEF, 2'd2, 10, acc, low);
        refTime = acceptTime;
        applyStimulus(16'h1234, 24'h000077, 2'd0, 10, acc, low);
        checkOutput("accNull", 32'(acc), 32'd1);
        waitDone(refTime, 60, rwLat, busyLat);
        checkOutput("wrapRwFall", 32'(rwLat), 32'd13);
        checkOutput("nullCost", 32'(busyLat - rwLat), 32'd1);
        checkOutput("wrapLogSize", 32'(busLog.size()), 32'd2);
        checkOutput("wrapb0", 32'(busLog[0]), 32'hFFFFEF);
        checkOutput("wrapb1", 32'(busLog[1]), 32'h0000BE);
        busLog.delete();
        riseLog.delete();

        // Reset pulse during the first strobe of a queued command
        applyStimulus(16'h0300, 24'h778899, 2'd3, 10, acc, low);
        applyStimulus(16'h0400, 24'h000055, 2'd1, 10, acc, low);
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clock);
            if (BusClock) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("strobeSeen", 32'(found), 32'd1);
        #1 Reset = 1'b0;
        #1;
        logAtReset = busLog.size();
        checkOutput("midRstClk", 32'(BusClock), 32'd0);
        checkOutput("midRstRw", 32'(BusReadWrite), 32'd0);
        checkOutput("midRstBusy", 32'(Busy), 32'd0);
        checkOutput("midRstAddr", 32'(BusAddress), 32'h0000);
        checkOutput("midRstLog", 32'(logAtReset), 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (40) @(negedge Clock);
        checkOutput("postRstLog", 32'(busLog.size()), 32'd1);
        checkOutput("postRstBusy", 32'(Busy), 32'd0);
        checkOutput("postRstReady", 32'(CmdReady), 32'd1);
        checkOutput("postRstRw", 32'(BusReadWrite), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
